// File: rtl/min_digit_rx.sv
// min_digit_rx
// Receive-side companion of the minutes-units counter. Samples the BCD minute
// digit and the divided 1/600 Hz clock coming from the counter, produces
// registered 7-segment and one-hot decodes, and checks that the stream obeys
// the counting protocol: +1 modulo (MAX_DIGIT+1), and a divided-clock toggle
// after digits 4 and 9. After an error it enters a hold state and needs
// LOCK_RUN consecutive good transitions before it reports valid again.
//
// Ports:
//   rstn_i     asynchronous active-low reset
//   clk1m_i    1/60 Hz clock shared with the counter (rising edge)
//   digit_i    BCD minute digit from the counter
//   clk10m_i   registered divided clock from the counter (resets to 1 there)
//   seg_o      registered segments {g,f,e,d,c,b,a}
//   onehot_o   registered one-hot digit decode
//   valid_o    high while locked to the stream
//   err_o      sticky protocol-error flag
//   err_cnt_o  saturating count of error events

module min_digit_rx #(
    parameter int MAX_DIGIT      = 9,
    parameter int LOCK_RUN       = 2,
    parameter int ERR_CNT_W      = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                 rstn_i,
    input  logic                 clk1m_i,
    input  logic [3:0]           digit_i,
    input  logic                 clk10m_i,
    output logic [6:0]           seg_o,
    output logic [9:0]           onehot_o,
    output logic                 valid_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {SYNC, LOCKED, HOLD} state_t;

    localparam logic [3:0] MAX_D      = 4'(MAX_DIGIT);
    localparam logic [2:0] RUN_TARGET = 3'(LOCK_RUN);
    localparam logic [6:0] SEG_XOR    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t     state;
    state_t     state_next;
    logic [3:0] prev_digit;
    logic       prev_clk;
    logic [2:0] run_cnt;
    logic [2:0] run_next;
    logic [2:0] run_inc;
    logic       sample_valid;
    logic       in_table;
    logic [3:0] expected_digit;
    logic       toggle_due;
    logic       toggled;
    logic       good;
    logic       err_event;
    logic [6:0] seg_pat;
    logic [9:0] onehot_pat;

    // A transition is good only if the digit is legal, is the successor of
    // the reference, and the divided clock toggled exactly when the
    // reference digit was 4 or 9. A step error and a toggle error on the
    // same edge collapse into a single error event.
    assign sample_valid   = (digit_i <= MAX_D);
    assign in_table       = sample_valid && (digit_i <= 4'd9);
    assign expected_digit = (prev_digit == MAX_D) ? 4'd0 : prev_digit + 4'd1;
    assign toggle_due     = (prev_digit == 4'd4) || (prev_digit == 4'd9);
    assign toggled        = (clk10m_i != prev_clk);
    assign good           = sample_valid && (digit_i == expected_digit)
                            && (toggled == toggle_due);
    assign run_inc        = run_cnt + 3'd1;

    assign valid_o = (state == LOCKED);

    // Display decode; anything outside the legal digit range shows blank.
    always_comb begin
        seg_pat    = 7'h00;
        onehot_pat = '0;
        if (in_table) begin
            onehot_pat = 10'd1 << digit_i;
            case (digit_i)
                4'd0:    seg_pat = 7'h3F;
                4'd1:    seg_pat = 7'h06;
                4'd2:    seg_pat = 7'h5B;
                4'd3:    seg_pat = 7'h4F;
                4'd4:    seg_pat = 7'h66;
                4'd5:    seg_pat = 7'h6D;
                4'd6:    seg_pat = 7'h7D;
                4'd7:    seg_pat = 7'h07;
                4'd8:    seg_pat = 7'h7F;
                4'd9:    seg_pat = 7'h6F;
                default: seg_pat = 7'h00;
            endcase
        end
    end

    // Lock tracking. SYNC takes the first legal sample as reference without
    // checking it; every non-good sample afterwards is an error event.
    always_comb begin
        state_next = state;
        run_next   = run_cnt;
        err_event  = 1'b0;
        case (state)
            SYNC: begin
                if (sample_valid) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (!good) begin
                    state_next = HOLD;
                    run_next   = '0;
                    err_event  = 1'b1;
                end
            end
            HOLD: begin
                if (good) begin
                    if (run_inc == RUN_TARGET) begin
                        state_next = LOCKED;
                        run_next   = '0;
                    end else begin
                        run_next = run_inc;
                    end
                end else begin
                    run_next  = '0;
                    err_event = 1'b1;
                end
            end
            default: begin
                state_next = SYNC;
                run_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk1m_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= SYNC;
            run_cnt    <= '0;
            prev_digit <= 4'd0;
            prev_clk   <= 1'b1;
        end else begin
            state   <= state_next;
            run_cnt <= run_next;
            // Invalid samples never replace the reference, so the stream can
            // recover on the digit that was actually due.
            if (sample_valid) begin
                prev_digit <= digit_i;
                prev_clk   <= clk10m_i;
            end
        end
    end

    always_ff @(posedge clk1m_i or negedge rstn_i) begin
        if (!rstn_i) begin
            seg_o     <= SEG_XOR;
            onehot_o  <= '0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            seg_o    <= seg_pat ^ SEG_XOR;
            onehot_o <= onehot_pat;
            if (err_event) begin
                err_o <= 1'b1;
                if (err_cnt_o != {ERR_CNT_W{1'b1}}) begin
                    err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_min_digit_rx.sv
// tb_min_digit_rx
// Drives three instances of min_digit_rx from one shared stream: default
// parameters, a 2-bit error counter, and active-low segments. A counter
// generator produces the legal stream; faults are injected on top of it.
// Expected outputs come from a reference model that tracks the reference
// digit and, after synchronisation, counts error events and the run of good
// transitions since the last error; valid is implied by that run length.

module tb_min_digit_rx;

    localparam int LOCK_RUN = 2;

    logic       clk1m = 1'b0;
    logic       rstn;
    logic [3:0] digit;
    logic       clk10m;

    logic [6:0] seg, seg_sat, seg_al;
    logic [9:0] onehot, onehot_sat, onehot_al;
    logic       valid, valid_sat, valid_al;
    logic       err, err_sat, err_al;
    logic [3:0] err_cnt, err_cnt_al;
    logic [1:0] err_cnt_sat;

    min_digit_rx #(.MAX_DIGIT(9), .LOCK_RUN(LOCK_RUN), .ERR_CNT_W(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .rstn_i(rstn), .clk1m_i(clk1m), .digit_i(digit), .clk10m_i(clk10m),
        .seg_o(seg), .onehot_o(onehot), .valid_o(valid), .err_o(err), .err_cnt_o(err_cnt)
    );

    min_digit_rx #(.MAX_DIGIT(9), .LOCK_RUN(LOCK_RUN), .ERR_CNT_W(2), .SEG_ACTIVE_LOW(1'b0)) dut_sat (
        .rstn_i(rstn), .clk1m_i(clk1m), .digit_i(digit), .clk10m_i(clk10m),
        .seg_o(seg_sat), .onehot_o(onehot_sat), .valid_o(valid_sat), .err_o(err_sat),
        .err_cnt_o(err_cnt_sat)
    );

    min_digit_rx #(.MAX_DIGIT(9), .LOCK_RUN(LOCK_RUN), .ERR_CNT_W(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .rstn_i(rstn), .clk1m_i(clk1m), .digit_i(digit), .clk10m_i(clk10m),
        .seg_o(seg_al), .onehot_o(onehot_al), .valid_o(valid_al), .err_o(err_al),
        .err_cnt_o(err_cnt_al)
    );

    always #5 clk1m = ~clk1m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // counter generator: last value presented by the source counter
    int   gen_d;
    logic gen_c;

    // reference model
    int         synced;
    int         ref_d;
    logic       ref_c;
    int         errors;
    int         streak;
    logic [6:0] exp_seg;
    logic [9:0] exp_onehot;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        synced     = 0;
        ref_d      = 0;
        ref_c      = 1'b1;
        errors     = 0;
        streak     = 0;
        exp_seg    = 7'h00;
        exp_onehot = '0;
    endtask

    task automatic model_sample(input logic [3:0] d, input logic c);
        int di;
        bit good;
        di = int'(d);
        if (di <= 9) begin
            exp_seg    = seg_tab[di];
            exp_onehot = 10'(1 << di);
        end else begin
            exp_seg    = 7'h00;
            exp_onehot = '0;
        end
        if (synced == 0) begin
            if (di <= 9) begin
                synced = 1;
                ref_d  = di;
                ref_c  = c;
            end
        end else begin
            good = (di <= 9) && (di == (ref_d + 1) % 10) && ((c != ref_c) == (ref_d % 5 == 4));
            if (good) begin
                streak++;
            end else begin
                errors++;
                streak = 0;
            end
            if (di <= 9) begin
                ref_d = di;
                ref_c = c;
            end
        end
    endtask

    task automatic check_output(input string tag);
        logic exp_valid;
        int   cnt4;
        int   cnt2;
        exp_valid = (synced != 0) && (errors == 0 || streak >= LOCK_RUN);
        cnt4 = (errors > 15) ? 15 : errors;
        cnt2 = (errors > 3) ? 3 : errors;
        check_val({tag, ".seg"},       16'(seg),        16'(exp_seg));
        check_val({tag, ".seg_al"},    16'(seg_al),     16'(exp_seg ^ 7'h7F));
        check_val({tag, ".onehot"},    16'(onehot),     16'(exp_onehot));
        check_val({tag, ".valid"},     16'(valid),      16'(exp_valid));
        check_val({tag, ".valid_sat"}, 16'(valid_sat),  16'(exp_valid));
        check_val({tag, ".err"},       16'(err),        16'(errors > 0));
        check_val({tag, ".err_cnt"},   16'(err_cnt),    16'(cnt4));
        check_val({tag, ".err_cnt2"},  16'(err_cnt_sat), 16'(cnt2));
    endtask

    task automatic apply_stimulus(input logic [3:0] d, input logic c, input string tag);
        digit  = d;
        clk10m = c;
        @(posedge clk1m);
        model_sample(d, c);
        #1;
        check_output(tag);
    endtask

    task automatic advance();
        if (gen_d == 4 || gen_d == 9) gen_c = ~gen_c;
        gen_d = (gen_d == 9) ? 0 : gen_d + 1;
    endtask

    task automatic normal_step(input string tag);
        advance();
        apply_stimulus(4'(gen_d), gen_c, tag);
    endtask

    // called just after an active edge; checks that reset acts immediately
    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        model_reset();
        check_output({tag, ".async"});
        @(posedge clk1m);
        #1;
        check_output({tag, ".held"});
        rstn = 1'b1;
    endtask

    initial begin
        rstn   = 1'b1;
        digit  = 4'd7;
        clk10m = 1'b1;
        gen_d  = 6;
        gen_c  = 1'b1;
        model_reset();

        #1 rstn = 1'b0;
        #1 check_output("reset");
        @(posedge clk1m);
        #1 check_output("reset_held");
        rstn = 1'b1;

        // startup from 7 with the counter running
        for (int i = 0; i < 5; i++) begin
            normal_step("startup");
            if (gen_d == 0) begin
                check_val("startup.valid_at_0", 16'(valid), 16'd1);
                check_val("startup.seg_at_0", 16'(seg), 16'h3F);
                check_val("startup.err_at_0", 16'(err), 16'd0);
            end
        end

        // two full wraps
        for (int i = 0; i < 20; i++) begin
            normal_step("wrap");
            check_val("wrap.onehot_walk", 16'(onehot), 16'(1 << gen_d));
        end

        // skip 5 -> 7 while locked
        for (int i = 0; i < 10 && gen_d != 5; i++) normal_step("pre_skip");
        advance();
        advance();
        apply_stimulus(4'(gen_d), gen_c, "skip");
        check_val("skip.valid", 16'(valid), 16'd0);
        check_val("skip.err_cnt", 16'(err_cnt), 16'd1);
        normal_step("skip_rec1");
        check_val("skip_rec1.valid", 16'(valid), 16'd0);
        normal_step("skip_rec2");
        check_val("skip_rec2.valid", 16'(valid), 16'd1);

        // missing toggle 4 -> 5; an illegal digit first shows SYNC ignores it
        do_reset("rst_toggle");
        apply_stimulus(4'hE, gen_c, "sync_invalid");
        check_val("sync_invalid.err", 16'(err), 16'd0);
        for (int i = 0; i < 12 && gen_d != 4; i++) normal_step("pre_toggle");
        advance();
        gen_c = ~gen_c;
        apply_stimulus(4'(gen_d), gen_c, "no_toggle");
        check_val("no_toggle.err_cnt", 16'(err_cnt), 16'd1);
        check_val("no_toggle.valid", 16'(valid), 16'd0);
        for (int i = 0; i < 3; i++) normal_step("toggle_rec");

        // illegal digit while locked; reference must be kept
        apply_stimulus(4'hC, gen_c, "invalid_c");
        check_val("invalid_c.seg", 16'(seg), 16'h00);
        check_val("invalid_c.onehot", 16'(onehot), 16'h000);
        check_val("invalid_c.err_cnt", 16'(err_cnt), 16'd2);
        normal_step("after_c");
        check_val("after_c.err_cnt", 16'(err_cnt), 16'd2);
        normal_step("after_c2");

        // held digit
        apply_stimulus(4'(gen_d), gen_c, "held");
        check_val("held.err_cnt", 16'(err_cnt), 16'd3);
        for (int i = 0; i < 3; i++) normal_step("held_rec");

        // randomized stream with injected faults
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0: begin advance(); advance(); apply_stimulus(4'(gen_d), gen_c, "rnd_skip"); end
                1: apply_stimulus(4'(gen_d), gen_c, "rnd_hold");
                2: begin advance(); gen_c = ~gen_c; apply_stimulus(4'(gen_d), gen_c, "rnd_toggle"); end
                3: apply_stimulus(4'(10 + $urandom_range(0, 5)), gen_c, "rnd_invalid");
                default: normal_step("rnd_good");
            endcase
        end

        // saturation of the 2-bit counter, then reset mid-stream
        do_reset("rst_sat");
        normal_step("sat_sync");
        for (int i = 0; i < 5; i++) apply_stimulus(4'(gen_d), gen_c, "sat_hold");
        check_val("sat.err_cnt2", 16'(err_cnt_sat), 16'd3);
        check_val("sat.err_cnt4", 16'(err_cnt), 16'd5);
        do_reset("rst_mid");
        check_val("rst_mid.err_cnt2", 16'(err_cnt_sat), 16'd0);
        for (int i = 0; i < 4; i++) normal_step("resync");

        $display("[TB] stream finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
